// File: rtl/cci_mpf_active_req_tracker.sv
`default_nettype none
// ============================================================================
// Module   : cci_mpf_active_req_tracker
// Purpose  : N-channel outstanding-request tracker at the AFU edge of MPF.
//            Per channel it counts requests issued minus requests retired,
//            reports registered not-empty / almost-full status, and records
//            sticky overflow / underflow errors. A drain handshake blocks new
//            issue and acknowledges once every channel count is zero.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            i_req_incr[N]       - per-channel request issued (SOP) pulse
//            i_rsp_decr[N]       - per-channel request retired (EOP) pulse
//            i_drain_req         - level request to drain all channels
//            o_not_empty[N]      - channel has or just accepted a request
//            o_almost_full[N]    - channel count >= ALMOST_FULL_THRESH
//            o_drain_block       - upstream must stop issuing
//            o_drain_ack         - drain complete, all counts zero
//            o_err_overflow[N]   - sticky: increment at saturation
//            o_err_underflow[N]  - sticky: decrement at zero
// Option   : CCI_MPF_ACTIVE_TRACK_STATS_EN adds i_stats_clear, o_hwm
//            (per-channel high-water mark) and o_total_reqs (per-channel
//            32-bit wrapping issue count).
// Revision : 1.0 - initial release
// ============================================================================
module cci_mpf_active_req_tracker #(
  parameter int N_CHANNELS         = 2,
  parameter int MAX_ACTIVE_REQS    = 1024,
  parameter int ALMOST_FULL_THRESH = 960,
  localparam int CNT_W             = $clog2(MAX_ACTIVE_REQS) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CHANNELS-1:0]       i_req_incr,
  input  logic [N_CHANNELS-1:0]       i_rsp_decr,
  input  logic                        i_drain_req,
`ifdef CCI_MPF_ACTIVE_TRACK_STATS_EN
  input  logic                        i_stats_clear,
  output logic [N_CHANNELS*CNT_W-1:0] o_hwm,
  output logic [N_CHANNELS*32-1:0]    o_total_reqs,
`endif
  output logic [N_CHANNELS-1:0]       o_not_empty,
  output logic [N_CHANNELS-1:0]       o_almost_full,
  output logic                        o_drain_block,
  output logic                        o_drain_ack,
  output logic [N_CHANNELS-1:0]       o_err_overflow,
  output logic [N_CHANNELS-1:0]       o_err_underflow
);

  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_AF_THRESH = CNT_W'(ALMOST_FULL_THRESH);

  // Per-channel "count is zero" using the current (pre-update) count.
  logic [N_CHANNELS-1:0] w_cnt_zero;

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_not_empty;
    logic             r_almost_full;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic             w_inc_only;
    logic             w_dec_only;

    // Simultaneous incr and decr cancel, even at zero or saturation.
    assign w_inc_only = i_req_incr[gi] & ~i_rsp_decr[gi];
    assign w_dec_only = i_rsp_decr[gi] & ~i_req_incr[gi];

    always_comb begin
      w_cnt_next = r_cnt;
      if (w_inc_only && (r_cnt != c_CNT_MAX)) begin
        w_cnt_next = r_cnt + c_CNT_ONE;
      end else if (w_dec_only && (r_cnt != '0)) begin
        w_cnt_next = r_cnt - c_CNT_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt         <= '0;
        r_not_empty   <= 1'b0;
        r_almost_full <= 1'b0;
        r_err_ovf     <= 1'b0;
        r_err_unf     <= 1'b0;
      end else begin
        r_cnt         <= w_cnt_next;
        // Pre-update count: stays high one cycle past the final retire.
        r_not_empty   <= i_req_incr[gi] | (r_cnt != '0);
        r_almost_full <= (w_cnt_next >= c_AF_THRESH);
        if (w_inc_only && (r_cnt == c_CNT_MAX)) r_err_ovf <= 1'b1;
        if (w_dec_only && (r_cnt == '0))        r_err_unf <= 1'b1;
      end
    end

    assign w_cnt_zero[gi]      = (r_cnt == '0);
    assign o_not_empty[gi]     = r_not_empty;
    assign o_almost_full[gi]   = r_almost_full;
    assign o_err_overflow[gi]  = r_err_ovf;
    assign o_err_underflow[gi] = r_err_unf;

`ifdef CCI_MPF_ACTIVE_TRACK_STATS_EN
    logic [CNT_W-1:0] r_hwm;
    logic [31:0]      r_total;

    // A clear wins over any same-cycle update.
    always_ff @(posedge clk) begin
      if (reset || i_stats_clear) begin
        r_hwm   <= '0;
        r_total <= '0;
      end else begin
        if (w_cnt_next > r_hwm) r_hwm <= w_cnt_next;
        r_total <= r_total + {31'd0, i_req_incr[gi]};
      end
    end

    assign o_hwm[gi*CNT_W +: CNT_W] = r_hwm;
    assign o_total_reqs[gi*32 +: 32] = r_total;
`endif
  end

  // --------------------------------------------------------------------------
  // Drain handshake FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLOCK = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_drain_block;
  logic   r_drain_ack;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_drain_req) w_state_next = S_BLOCK;
      // One-cycle dwell absorbs a request already in flight upstream.
      S_BLOCK: w_state_next = S_WAIT;
      S_WAIT: begin
        if (!i_drain_req) begin
          w_state_next = S_IDLE;
        end else if ((&w_cnt_zero) && !(|i_req_incr)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  if (!i_drain_req) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state
  // register exactly without a decode stage on the output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_drain_block <= 1'b0;
      r_drain_ack   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_drain_block <= (w_state_next != S_IDLE);
      r_drain_ack   <= (w_state_next == S_DONE);
    end
  end

  assign o_drain_block = r_drain_block;
  assign o_drain_ack   = r_drain_ack;

endmodule
`default_nettype wire

// File: tb/tb_cci_mpf_active_req_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_mpf_active_req_tracker
// Purpose  : Scoreboard bench for cci_mpf_active_req_tracker. A driver issues
//            directed and random per-cycle stimulus, advances a behavioural
//            model and queues the expected registered outputs; a monitor pops
//            and compares after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cci_mpf_active_req_tracker;

  localparam int N    = 2;
  localparam int MAXR = 4;
  localparam int THR  = 4;
  localparam int CW   = $clog2(MAXR) + 1;
  localparam int CSAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  i_req_incr = '0;
  logic [N-1:0]  i_rsp_decr = '0;
  logic          i_drain_req = 1'b0;
  logic [N-1:0]  o_not_empty, o_almost_full, o_err_overflow, o_err_underflow;
  logic          o_drain_block, o_drain_ack;
`ifdef CCI_MPF_ACTIVE_TRACK_STATS_EN
  logic          i_stats_clear = 1'b0;
  logic [N*CW-1:0] o_hwm;
  logic [N*32-1:0] o_total_reqs;
`endif

  cci_mpf_active_req_tracker #(
    .N_CHANNELS(N), .MAX_ACTIVE_REQS(MAXR), .ALMOST_FULL_THRESH(THR)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_incr(i_req_incr), .i_rsp_decr(i_rsp_decr), .i_drain_req(i_drain_req),
`ifdef CCI_MPF_ACTIVE_TRACK_STATS_EN
    .i_stats_clear(i_stats_clear), .o_hwm(o_hwm), .o_total_reqs(o_total_reqs),
`endif
    .o_not_empty(o_not_empty), .o_almost_full(o_almost_full),
    .o_drain_block(o_drain_block), .o_drain_ack(o_drain_ack),
    .o_err_overflow(o_err_overflow), .o_err_underflow(o_err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    ne, af, ovf, unf;
    logic            blk, ack;
    logic [N*CW-1:0] hwm;
    logic [N*32-1:0] tot;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Behavioural model state
  int          m_cnt[N];
  bit          m_ovf[N], m_unf[N];
  int          m_hwm[N];
  int unsigned m_tot[N];
  bit          m_draining;   // drain requested and block asserted
  int          m_settle;     // cycles left before emptiness may be acknowledged
  bit          m_acked;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: compares the outputs produced by the edge that consumed the
  // oldest queued stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("not_empty",     64'(o_not_empty),     64'(e.ne));
        chk("almost_full",   64'(o_almost_full),   64'(e.af));
        chk("drain_block",   64'(o_drain_block),   64'(e.blk));
        chk("drain_ack",     64'(o_drain_ack),     64'(e.ack));
        chk("err_overflow",  64'(o_err_overflow),  64'(e.ovf));
        chk("err_underflow", 64'(o_err_underflow), 64'(e.unf));
`ifdef CCI_MPF_ACTIVE_TRACK_STATS_EN
        chk("hwm",        64'(o_hwm),        64'(e.hwm));
        chk("total_reqs", 64'(o_total_reqs), 64'(e.tot));
`endif
      end
    end
  end

  // Drive one cycle of stimulus and queue the outputs it must produce.
  task automatic step(input logic [N-1:0] incr, input logic [N-1:0] decr,
                      input logic dreq, input logic rst, input logic sclr);
    exp_t e;
    bit   all_zero;
    @(negedge clk);
    i_req_incr  = incr;
    i_rsp_decr  = decr;
    i_drain_req = dreq;
    reset       = rst;
`ifdef CCI_MPF_ACTIVE_TRACK_STATS_EN
    i_stats_clear = sclr;
`endif
    e.ne = '0; e.af = '0; e.ovf = '0; e.unf = '0; e.hwm = '0; e.tot = '0;
    e.blk = 1'b0; e.ack = 1'b0;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0; m_ovf[c] = 0; m_unf[c] = 0; m_hwm[c] = 0; m_tot[c] = 0;
      end
      m_draining = 0; m_settle = 0; m_acked = 0;
    end else begin
      all_zero = 1;
      for (int c = 0; c < N; c++) if (m_cnt[c] != 0) all_zero = 0;
      for (int c = 0; c < N; c++) begin
        e.ne[c] = incr[c] || (m_cnt[c] != 0);
        if (incr[c] && !decr[c]) begin
          if (m_cnt[c] == CSAT) m_ovf[c] = 1; else m_cnt[c]++;
        end else if (decr[c] && !incr[c]) begin
          if (m_cnt[c] == 0) m_unf[c] = 1; else m_cnt[c]--;
        end
        e.af[c] = (m_cnt[c] >= THR);
        if (sclr) begin
          m_hwm[c] = 0; m_tot[c] = 0;
        end else begin
          if (m_cnt[c] > m_hwm[c]) m_hwm[c] = m_cnt[c];
          m_tot[c] += int'(incr[c]);
        end
      end
      // Drain rules: block starts on the request, one absorb cycle follows,
      // then ack once counts are zero with no issue; dropping the request
      // after the absorb cycle always returns to idle.
      if (!m_draining) begin
        if (dreq) begin m_draining = 1; m_settle = 1; m_acked = 0; end
      end else if (m_settle > 0) begin
        m_settle = 0;
      end else if (!dreq) begin
        m_draining = 0; m_acked = 0;
      end else if (!m_acked && all_zero && incr == '0) begin
        m_acked = 1;
      end
      e.blk = m_draining;
      e.ack = m_acked;
      for (int c = 0; c < N; c++) begin
        e.ovf[c] = m_ovf[c];
        e.unf[c] = m_unf[c];
        e.hwm[c*CW +: CW] = CW'(m_hwm[c]);
        e.tot[c*32 +: 32] = m_tot[c];
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic dreq);
    for (int k = 0; k < n; k++) step('0, '0, dreq, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step('0, '0, 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [N-1:0] ri, rd;
    logic         rq;
    do_reset();
    idle(2, 1'b0);

    // Single channel count up/down
    for (int k = 0; k < 5; k++) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Simultaneous events at zero, then underflow
    for (int k = 0; k < 10; k++) step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Threshold and saturation
    do_reset();
    for (int k = 0; k < 8; k++) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    do_reset();

    // Drain with traffic on ch1
    for (int k = 0; k < 3; k++) step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    idle(3, 1'b0);

    // Drain on empty, then abort in WAIT
    idle(5, 1'b1);
    idle(2, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);
    idle(2, 1'b0);
    for (int k = 0; k < 2; k++) step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);

    // Reset mid-drain
    step(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Statistics accumulate and clear
    for (int k = 0; k < 6; k++) step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);

    // Randomised traffic, drains and clears
    rq = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        ri[c] = ($urandom_range(99) < 40);
        rd[c] = ($urandom_range(99) < 40);
      end
      if ($urandom_range(99) < 6) rq = ~rq;
      step(ri, rd, rq, ($urandom_range(999) < 3), ($urandom_range(99) < 2));
    end
    idle(3, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain left=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
